pwm_duty_decoder: RTL
=====================

Name: pwm_duty_decoder

Overview:
Receive-side counterpart of the team's PWM generator. It samples an incoming PWM line, aligns to its rising edges, and measures high cycles per frame. It reports the duty code on the same scale the generator accepts: 0..PERIOD high cycles per PERIOD-cycle frame. It is used for loopback checking and for decoding PWM commands arriving from off-chip.

Parameters:
PERIOD, 10, expected frame length in SLK cycles; duty code full scale
DW, 4, width of duty_out; must satisfy 2^DW > PERIOD
CW, derived localparam = ceil(log2(2*PERIOD+1)), width of internal cycle counters

Ports:
SLK  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
pwm_in  input  1  PWM line, asynchronous to SLK
duty_out  output  DW  last measured duty code, 0..PERIOD
duty_valid  output  1  one-cycle strobe; duty_out/period_err updated this cycle
period_err  output  1  last closed frame length != PERIOD (sticky until next publish)

Behaviour:
- Interface: one clock SLK; reset rst_n is asynchronous, active-low.
- Reset (async, any time incl. mid-frame): duty_out=0, duty_valid=0, period_err=0, sync flops s1/s2/s3=0, counters=0, state=WAIT_EDGE.
- Input path: 2-flop synchroniser s1->s2, s3 = previous s2. rise = s2 & ~s3. A line held high through reset therefore produces one rise after release.
- Counters:
  - per_cnt counts cycles in the current frame.
  - hi_cnt counts cycles with s2=1.
  - Both saturate at 2*PERIOD and never wrap.
- State WAIT_EDGE (no frame alignment):
  - per_cnt increments each cycle.
  - on rise: go to MEASURE, per_cnt<=1, hi_cnt<=1.
  - else if per_cnt==PERIOD-1: publish constant level (duty_out <= s2 ? PERIOD : 0, period_err<=0, duty_valid<=1), per_cnt<=0.
  - rise has priority over the timeout in the same cycle.
- State MEASURE:
  - each non-rise cycle: per_cnt+=1, hi_cnt+=s2.
  - on rise: close frame.
    - duty_out <= min(hi_cnt, PERIOD)
    - period_err <= (per_cnt != PERIOD)
    - duty_valid <= 1
    - restart with per_cnt<=1, hi_cnt<=1; stay in MEASURE.
  - if per_cnt reaches 2*PERIOD with no rise (line stuck): publish constant level as in WAIT_EDGE, period_err<=0, go to WAIT_EDGE with per_cnt<=0.
- Publishing:
  - Registered. duty_valid is high exactly one cycle per publish; 0 otherwise.
  - duty_out and period_err hold between publishes.
- Latency: for a frame closed by a pwm_in rise sampled at SLK edge k, duty_valid is high in the cycle following edge k+3 (2 sync + edge detect + output reg).
- 0% and 100% inputs (line constant) decode via timeout to 0 / PERIOD, with no period_err.
- First partial frame after reset or after WAIT_EDGE is never published as a measured frame; only complete rise-to-rise frames are.
- Glitch shorter than one SLK period may be missed; no filtering beyond the synchroniser.

Test Plan:
- Reset, then drive the generator pattern with PERIOD=10 and duty 3 (3 high, 7 low, repeating). Required: from the second rise onward, duty_valid pulses every 10 cycles with duty_out=3 and period_err=0.
- Step the duty 3 -> 7 mid-stream at a frame boundary. Required: the next publish shows 7, with no spurious intermediate value.
- Hold pwm_in low for 40 cycles after reset. Required: duty_valid pulses every 10 cycles with duty_out=0 and period_err=0. Hold high instead: after one rise, a timeout at 20 cycles gives duty_out=10, then every 10 cycles.
- Frame of 12 cycles with 5 high. Required: duty_out=5, period_err=1. Frame of 16 cycles with 14 high: duty_out=10 (saturated), period_err=1. The following correct 10-cycle frame clears period_err to 0.
- Assert rst_n=0 mid-frame (per_cnt=6, duty_out=4). Required: all outputs 0 immediately, without waiting for SLK. After release with the 4-duty pattern, the first publish is 4, only after a full rise-to-rise frame.
- Apply a rise on the same cycle per_cnt==PERIOD-1 in WAIT_EDGE. Required: no constant-level publish; the state enters MEASURE.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high cycles per rise-to-rise PWM frame.
// Ports: SLK, rst_n, pwm_in -> duty_out[DW], duty_valid, period_err.
module pwm_duty_decoder #(
  parameter int PERIOD = 10,
  parameter int DW     = 4
) (
  input  logic          SLK,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [DW-1:0] duty_out,
  output logic          duty_valid,
  output logic          period_err
);

  localparam int CW = $clog2(2*PERIOD+1);

  localparam logic [CW-1:0] PER  = CW'(PERIOD);
  localparam logic [CW-1:0] TMO1 = CW'(PERIOD-1);
  localparam logic [CW-1:0] MAXC = CW'(2*PERIOD);
  localparam logic [DW-1:0] FULL = DW'(PERIOD);

  typedef enum logic {
    WAIT_EDGE,
    MEASURE
  } state_t;

  state_t        state_q;
  logic          s1_q, s2_q, s3_q;
  logic          rise_q, lvl_q;
  logic [CW-1:0] per_q, hi_q;
  logic [DW-1:0] duty_q;
  logic          valid_q, err_q;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v == MAXC) ? v : v + 1'b1;
  endfunction

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign period_err = err_q;

  // rise_q is the registered edge detect; lvl_q is s2 delayed
  // by the same stage so level and edge describe one sample.
  always_ff @(posedge SLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_EDGE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      rise_q  <= 1'b0;
      lvl_q   <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      rise_q  <= s2_q & ~s3_q;
      lvl_q   <= s2_q;
      valid_q <= 1'b0;
      unique case (state_q)
        WAIT_EDGE: begin
          if (rise_q) begin
            state_q <= MEASURE;
            per_q   <= CW'(1);
            hi_q    <= CW'(1);
          end else if (per_q == TMO1) begin
            duty_q  <= lvl_q ? FULL : '0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            per_q   <= '0;
          end else begin
            per_q <= sat_inc(per_q);
          end
        end
        MEASURE: begin
          if (rise_q) begin
            duty_q  <= (hi_q > PER) ? FULL : DW'(hi_q);
            err_q   <= (per_q != PER);
            valid_q <= 1'b1;
            per_q   <= CW'(1);
            hi_q    <= CW'(1);
          end else if (per_q == MAXC) begin
            // no rise for two frames: line is stuck
            duty_q  <= lvl_q ? FULL : '0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            per_q   <= '0;
            state_q <= WAIT_EDGE;
          end else begin
            per_q <= sat_inc(per_q);
            if (lvl_q) hi_q <= sat_inc(hi_q);
          end
        end
      endcase
    end
  end

endmodule
